// File: rtl/pulse_train_pkg.sv
// Shared types and helpers for the burst pulse generator.
package pulse_train_pkg;

  localparam int unsigned PT_STATE_W = 2;
  localparam int unsigned SAT_W      = 32;

  localparam logic [PT_STATE_W-1:0] PT_ENC_IDLE = 2'd0;
  localparam logic [PT_STATE_W-1:0] PT_ENC_HIGH = 2'd1;
  localparam logic [PT_STATE_W-1:0] PT_ENC_LOW  = 2'd2;

  typedef enum logic [PT_STATE_W-1:0] {
    PT_IDLE = PT_ENC_IDLE,
    PT_HIGH = PT_ENC_HIGH,
    PT_LOW  = PT_ENC_LOW
  } pt_state_e;

  // Phase lengths of zero behave as one cycle.
  function automatic logic [SAT_W-1:0] sat1(input logic [SAT_W-1:0] x);
    return (x == '0) ? SAT_W'(1) : x;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter timing one high or low phase; holds at zero.
module phase_timer #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  output logic             zero
);

  logic [DIV_W-1:0] phase_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else if (load) begin
      phase_q <= load_val;
    end else if (phase_q != '0) begin
      phase_q <= phase_q - DIV_W'(1);
    end
  end

  assign zero = (phase_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Burst pulse generator: N pulses of programmable high/low width, with
// back-to-back chaining, abort, and a registered clock-gate enable.
module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter int unsigned COUNT_W = 8,
  parameter int unsigned DIV_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_pulses,
  input  logic [DIV_W-1:0]   high_cycles,
  input  logic [DIV_W-1:0]   low_cycles,
  input  logic               abort,
  output logic               pulse_out,
  output logic               clk_gate_en,
  output logic [COUNT_W-1:0] pulse_idx,
  output logic               last_pulse,
  output logic               busy,
  output logic               done
);

  pt_state_e          state_q, state_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d, idx_d;
  logic [DIV_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [DIV_W-1:0]   hi_sat, lo_sat, load_val;
  logic               load, zero, done_d;
  logic               final_c, accept_c;

  assign hi_sat = DIV_W'(sat1(SAT_W'(high_cycles)));
  assign lo_sat = DIV_W'(sat1(SAT_W'(low_cycles)));

  phase_timer #(.DIV_W(DIV_W)) u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  // Last cycle of the final LOW phase is the only in-train start window.
  assign final_c  = (state_q == PT_LOW) && zero && (cnt_q == COUNT_W'(1));
  assign accept_c = start && (num_pulses != '0) && !abort &&
                    ((state_q == PT_IDLE) || final_c);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    idx_d    = pulse_idx;
    done_d   = 1'b0;
    load     = 1'b0;
    load_val = '0;

    if (abort) begin
      state_d  = PT_IDLE;
      idx_d    = '0;
      load     = 1'b1;
    end else begin
      case (state_q)
        PT_HIGH: begin
          if (zero) begin
            state_d  = PT_LOW;
            load     = 1'b1;
            load_val = lo_q - DIV_W'(1);
          end
        end
        PT_LOW: begin
          if (zero) begin
            if (cnt_q == COUNT_W'(1)) begin
              done_d  = 1'b1;
              state_d = PT_IDLE;
              idx_d   = '0;
            end else begin
              cnt_d    = cnt_q - COUNT_W'(1);
              idx_d    = pulse_idx + COUNT_W'(1);
              state_d  = PT_HIGH;
              load     = 1'b1;
              load_val = hi_q - DIV_W'(1);
            end
          end
        end
        default: ;
      endcase

      // A chained start overrides the return to IDLE; done still fires.
      if (accept_c) begin
        state_d  = PT_HIGH;
        cnt_d    = num_pulses;
        hi_d     = hi_sat;
        lo_d     = lo_sat;
        idx_d    = '0;
        load     = 1'b1;
        load_val = hi_sat - DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= PT_IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      pulse_out   <= 1'b0;
      clk_gate_en <= 1'b0;
      pulse_idx   <= '0;
      last_pulse  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      pulse_out   <= (state_d == PT_HIGH);
      clk_gate_en <= (state_d == PT_HIGH);
      pulse_idx   <= idx_d;
      last_pulse  <= (cnt_d == COUNT_W'(1)) && (state_d != PT_IDLE);
      busy        <= (state_d != PT_IDLE);
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed and random checks of pulse_train_gen against a train-timing model.
module tb_pulse_train_gen;

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic [7:0] num_pulses, high_cycles, low_cycles;
  logic       pulse_out, clk_gate_en, last_pulse, busy, done;
  logic [7:0] pulse_idx;

  logic       mx_start, mx_abort;
  logic [3:0] mx_num;
  logic [2:0] mx_hi, mx_lo;
  logic       mx_pulse, mx_cge, mx_last, mx_busy, mx_done;
  logic [3:0] mx_idx;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Model: a train is (N,H,L) plus the 1-based cycle offset t inside it.
  bit m_act  = 1'b0;
  bit m_done = 1'b0;
  int m_t = 0, m_n = 0, m_h = 1, m_l = 1;

  always #5 clk = ~clk;

  pulse_train_gen #(.COUNT_W(8), .DIV_W(8)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_pulses  (num_pulses),
    .high_cycles (high_cycles),
    .low_cycles  (low_cycles),
    .abort       (abort),
    .pulse_out   (pulse_out),
    .clk_gate_en (clk_gate_en),
    .pulse_idx   (pulse_idx),
    .last_pulse  (last_pulse),
    .busy        (busy),
    .done        (done)
  );

  pulse_train_gen #(.COUNT_W(4), .DIV_W(3)) u_max (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (mx_start),
    .num_pulses  (mx_num),
    .high_cycles (mx_hi),
    .low_cycles  (mx_lo),
    .abort       (mx_abort),
    .pulse_out   (mx_pulse),
    .clk_gate_en (mx_cge),
    .pulse_idx   (mx_idx),
    .last_pulse  (mx_last),
    .busy        (mx_busy),
    .done        (mx_done)
  );

  task automatic check(input string tag, input int obs, input int exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic step(input string tag);
    bit fin, acc, p, lst;
    int per, j;
    logic [12:0] exp_v, obs;
    fin = m_act && (m_t == m_n * (m_h + m_l));
    acc = start && (num_pulses != 0) && !abort && (!m_act || fin);
    if (!rst_n || abort) begin
      m_act  = 1'b0;
      m_done = 1'b0;
    end else begin
      m_done = fin;
      if (acc) begin
        m_act = 1'b1;
        m_t   = 1;
        m_n   = int'(num_pulses);
        m_h   = (high_cycles == 0) ? 1 : int'(high_cycles);
        m_l   = (low_cycles == 0) ? 1 : int'(low_cycles);
      end else if (fin) begin
        m_act = 1'b0;
      end else if (m_act) begin
        m_t++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    p = 1'b0; lst = 1'b0; j = 0;
    if (m_act) begin
      per = m_h + m_l;
      j   = (m_t - 1) / per;
      p   = ((m_t - 1) % per) < m_h;
      lst = (j == m_n - 1);
    end
    exp_v = {p, p, 8'(j), lst, m_act, m_done};
    obs   = {pulse_out, clk_gate_en, pulse_idx, last_pulse, busy, done};
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h (pulse,cge,idx,last,busy,done)",
             tag, cyc, obs, exp_v);
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic launch(input int n, input int h, input int l, input string tag);
    num_pulses  = 8'(n);
    high_cycles = 8'(h);
    low_cycles  = 8'(l);
    start       = 1'b1;
    step(tag);
    start       = 1'b0;
  endtask

  initial begin
    int busy_n, rise, max_idx;
    bit prev, got_done;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    num_pulses = '0; high_cycles = '0; low_cycles = '0;
    mx_start = 1'b0; mx_abort = 1'b0; mx_num = '0; mx_hi = '0; mx_lo = '0;

    run(2, "reset");
    rst_n = 1'b1;
    step("idle");

    // Reset in the middle of a train
    launch(5, 2, 2, "rst_mid");
    run(4, "rst_mid");
    rst_n = 1'b0;
    step("rst_mid_apply");
    rst_n = 1'b1;
    run(3, "rst_mid_after");

    launch(3, 2, 1, "basic");
    run(10, "basic");

    // Zero-length train is ignored; zero phase widths act as one cycle
    num_pulses = '0;
    start = 1'b1;
    run(3, "zero_n");
    start = 1'b0;
    launch(2, 0, 0, "zero_hl");
    run(6, "zero_hl");

    // Chained start on the final low cycle
    launch(2, 1, 1, "chain");
    run(3, "chain");
    launch(1, 3, 1, "chain2");
    run(6, "chain2");

    // Abort mid-train, then abort together with start while idle
    launch(4, 2, 2, "abort");
    run(5, "abort");
    abort = 1'b1;
    step("abort_apply");
    abort = 1'b0;
    run(4, "abort_after");
    abort = 1'b1; start = 1'b1; num_pulses = 8'd3;
    step("abort_start");
    abort = 1'b0; start = 1'b0;
    run(3, "abort_start_after");

    // Random traffic; inputs wander mid-train and must be ignored
    for (int i = 0; i < 400; i++) begin
      start       = ($urandom_range(0, 5) == 0);
      abort       = ($urandom_range(0, 49) == 0);
      rst_n       = ($urandom_range(0, 199) != 0);
      num_pulses  = 8'($urandom_range(0, 4));
      high_cycles = 8'($urandom_range(0, 3));
      low_cycles  = 8'($urandom_range(0, 3));
      step("random");
    end
    start = 1'b0; abort = 1'b0; rst_n = 1'b1;
    run(40, "drain");

    // Maximum train on the narrow instance
    mx_num = 4'd15; mx_hi = 3'd7; mx_lo = 3'd7; mx_start = 1'b1;
    @(posedge clk); #1;
    mx_start = 1'b0;
    busy_n = 0; rise = 0; max_idx = 0; prev = 1'b0; got_done = 1'b0;
    for (int i = 0; i < 260 && !got_done; i++) begin
      if (mx_busy) busy_n++;
      if (mx_pulse && !prev) rise++;
      prev = mx_pulse;
      if (int'(mx_idx) > max_idx) max_idx = int'(mx_idx);
      if (mx_done) got_done = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("max_done_seen", int'(got_done), 1);
    check("max_busy_cycles", busy_n, 210);
    check("max_rising_edges", rise, 15);
    check("max_pulse_idx", max_idx, 14);
    check("max_idle_busy", int'(mx_busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Parametrised burst pulse generator. A `start` request emits a train of `num_pulses` pulses, each with a programmable high width and low width in `clk` cycles. The block reports progress and completion, supports seamless back-to-back chaining and abort, and drives a registered enable for an external clock gate. It sits between control FSMs and downstream strobe or clock-burst consumers: serial shift bursts, ADC conversion trains, stepper pulses.

## Interface

Parameters:
- `COUNT_W`, 8 — width of the pulse count; max train length 2^COUNT_W−1.
- `DIV_W`, 8 — width of the high/low phase lengths, in cycles.

Ports (clock and reset first):
- `clk` in 1 — sole clock; all logic is on the rising edge.
- `rst_n` in 1 — synchronous, active-low reset.
- `start` in 1 — request a new train; sampled every cycle.
- `num_pulses` in COUNT_W — train length, captured on an accepted start; 0 means the start is ignored.
- `high_cycles` in DIV_W — high-phase length, captured on an accepted start; 0 is treated as 1.
- `low_cycles` in DIV_W — low-phase length, captured on an accepted start; 0 is treated as 1.
- `abort` in 1 — terminate the current train immediately.
- `pulse_out` out 1 — registered pulse output.
- `clk_gate_en` out 1 — registered copy of `pulse_out`, intended for an ICG. The block never ANDs `clk` itself.
- `pulse_idx` out COUNT_W — zero-based index of the current pulse; 0 when idle.
- `last_pulse` out 1 — high throughout the high and low phases of the final pulse.
- `busy` out 1 — high whenever the state is not IDLE.
- `done` out 1 — one-cycle strobe on normal completion.

## Operation

State machine:
- States are IDLE, HIGH and LOW.
- Captured registers: `cnt_q` (pulses remaining), `hi_q`, `lo_q`, `phase_q` (phase down-counter).

Start acceptance:
- A start is accepted when `start`=1, `num_pulses`≠0 and `abort`=0, and either:
  - the state is IDLE, or
  - it is the final cycle of the last pulse's LOW phase (chain).
- A start in any other state or cycle is ignored. There is no queuing.

Transitions:
- On an accepted start: go to HIGH. Set `phase_q`=max(`high_cycles`,1)−1, `cnt_q`=`num_pulses`, `pulse_idx`=0.
- HIGH with `phase_q`=0: go to LOW and load `phase_q`=`lo_q`−1. Otherwise decrement `phase_q`.
- LOW with `phase_q`=0:
  - If `cnt_q`=1: go to IDLE, or to HIGH if a chained start is accepted.
  - Otherwise: `cnt_q`−1, `pulse_idx`+1, go to HIGH and reload `phase_q`.
  - Otherwise (`phase_q`≠0): decrement `phase_q`.

Outputs:
- `pulse_out` and `clk_gate_en` are 1 exactly when the state is HIGH. Both are registered with the state.
- `last_pulse` = (`cnt_q`==1) & `busy`.
- `done` pulses for one cycle, in the cycle after the final LOW phase ends. This holds even when a chained train has started in that cycle.

Abort:
- `abort`=1 forces IDLE on the next edge, zeroes `pulse_idx`, and leaves `done` low.
- Abort has priority over start and over natural completion in the same cycle.

Reset:
- `rst_n`=0 forces IDLE on the next edge from any state.
- On the following cycle all outputs are 0: `pulse_out`, `clk_gate_en`, `pulse_idx`, `last_pulse`, `busy`, `done`.
- Captured registers reset to 0.

Arithmetic:
- All counters are unsigned and never wrap. Reloads occur only at `phase_q`=0.
- Inputs are sampled only on an accepted start. Changing them mid-train has no effect.

## Timing

- Latency: start accepted at edge k → `pulse_out`=1 and `busy`=1 from cycle k+1.
- Each pulse is high for H=max(`high_cycles`,1) cycles and low for L=max(`low_cycles`,1) cycles.
- The train occupies exactly N·(H+L) cycles. `done` is asserted in cycle k+1+N·(H+L).
- A chained start gives zero idle cycles: the first high cycle of the new train immediately follows the last low cycle of the old one.
- Minimum legal configuration is H=L=1, which gives a 50% duty square wave at `clk`/2.

## Structure

- Package `pulse_train_pkg` holds:
  - the `pt_state_e` enum (IDLE, HIGH, LOW);
  - localparams for state encoding;
  - a helper function `sat1(x)` that returns max(x,1).
- One sub-module, `phase_timer`: a loadable DIV_W down-counter with `load`, `load_val` and `zero` outputs. The top module holds the FSM, `cnt_q` and output registers.

## Test plan

1. Reset mid-train: N=5, H=L=2; assert `rst_n`=0 in cycle 6 → all outputs 0 the cycle after reset; no `done`.
2. Basic train: N=3, H=2, L=1 → `pulse_out` pattern 110110110 from k+1; `pulse_idx` 0,1,2; `last_pulse` over the final 3 cycles; `done` at k+10.
3. Zero handling: `num_pulses`=0 → no response, `busy` stays 0. `high_cycles`=0 and `low_cycles`=0 with N=2 → pattern 1010, `done` at k+5.
4. Chaining: N=2, H=L=1, then a second start (N=1, H=3) on the final low cycle → pattern 1010111 with no gap; `done` coincides with the first `1` of the second train.
5. Abort: N=4, H=L=2; abort in the 2nd high cycle of pulse 1 → `pulse_out`=0 next cycle, `busy`=0, `done` never asserted. Abort and start in the same idle cycle → no train.
6. Maximum sizes: COUNT_W=4, DIV_W=3 with N=15, H=7, L=7 → exactly 210 busy cycles, 15 rising edges, `pulse_idx` reaches 14 without wrap.
